// File: rtl/final_project_soc_pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map, STATUS bits, FSM encoding.
package final_project_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PLEN   = 3'd1;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLEAR  = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int unsigned STATUS_BUSY   = 0;
  localparam int unsigned STATUS_DONE   = 1;
  localparam int unsigned STATUS_IRQ_EN = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/final_project_soc_pio_pulse_out_timer.sv
// One-shot pulse timer: loads max(len,1), counts down, flags expiry on the final active cycle.
module pio_pulse_timer
  import final_project_soc_pio_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  output logic             active,
  output logic             expire
);

  pulse_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A load always wins, so a restart on the expiry cycle simply reloads.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (load) begin
      state_nxt = ST_ACTIVE;
      cnt_nxt   = (len == '0) ? CNT_W'(1) : len;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    active = (state == ST_ACTIVE);
    expire = (state == ST_ACTIVE) && (cnt == CNT_W'(1)) && !load && !clear;
  end

endmodule

// File: rtl/final_project_soc_pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear and a one-shot pulse engine.
// Optional pulse-done interrupt enabled by defining PIO_PULSE_IRQ_EN.
module final_project_soc_pio_pulse_out
  import final_project_soc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] pulse_mask;
  logic [CNT_W-1:0] plen;
  logic             done;
  logic             active;
  logic             expire;
  logic             pulse_load;
  logic             unused_wd;

  assign wr         = chipselect & ~write_n;
  assign pulse_load = wr && (address == ADDR_PULSE);
  assign unused_wd  = ^writedata;

  pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pulse_load),
    .clear   (1'b0),
    .len     (plen),
    .active  (active),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VAL;
      plen     <= CNT_W'(1);
    end else if (wr) begin
      case (address)
        ADDR_DATA:  data_reg <= writedata[WIDTH-1:0];
        ADDR_PLEN:  plen     <= writedata[CNT_W-1:0];
        ADDR_SET:   data_reg <= data_reg | writedata[WIDTH-1:0];
        ADDR_CLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Expiry takes priority over a same-edge W1C so a completion is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_mask <= '0;
      done       <= 1'b0;
    end else begin
      if (pulse_load)
        pulse_mask <= writedata[WIDTH-1:0];
      else if (expire)
        pulse_mask <= '0;

      if (expire)
        done <= 1'b1;
      else if (wr && (address == ADDR_STATUS) && writedata[STATUS_DONE])
        done <= 1'b0;
    end
  end

`ifdef PIO_PULSE_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      irq_en <= 1'b0;
    else if (wr && (address == ADDR_STATUS))
      irq_en <= writedata[STATUS_IRQ_EN];
  end

  always_comb irq = done & irq_en;
`else
  always_comb irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(data_reg);
      ADDR_PLEN: readdata = 32'(plen);
      ADDR_STATUS: begin
        readdata[STATUS_BUSY] = active;
        readdata[STATUS_DONE] = done;
`ifdef PIO_PULSE_IRQ_EN
        readdata[STATUS_IRQ_EN] = irq_en;
`endif
      end
      default: readdata = '0;
    endcase
  end

  always_comb out_port = data_reg | pulse_mask;

endmodule

// File: tb/tb_final_project_soc_pio_pulse_out.sv
// Directed bench for the pulse-capable output PIO: register table plus pulse/reset/irq sequences.
module tb_final_project_soc_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [7:0] RST_V = 8'h5A;

  final_project_soc_pio_pulse_out #(
    .WIDTH     (8),
    .CNT_W     (16),
    .RESET_VAL (RST_V)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00A5, 8'hA5};
    vecs[1] = '{1'b1, 3'd2, 32'h0000_000A, 3'd2, 32'h0,         8'hAF};
    vecs[2] = '{1'b1, 3'd3, 32'h0000_0081, 3'd0, 32'h0000_002E, 8'h2E};
    vecs[3] = '{1'b0, 3'd0, 32'h0,         3'd3, 32'h0,         8'h2E};
    vecs[4] = '{1'b0, 3'd0, 32'h0,         3'd4, 32'h0,         8'h2E};
    vecs[5] = '{1'b1, 3'd1, 32'h0001_2345, 3'd1, 32'h0000_2345, 8'h2E};
    vecs[6] = '{1'b1, 3'd6, 32'h0000_00FF, 3'd6, 32'h0,         8'h2E};
    vecs[7] = '{1'b1, 3'd7, 32'h0000_00FF, 3'd7, 32'h0,         8'h2E};
    vecs[8] = '{1'b0, 3'd0, 32'h0,         3'd5, 32'h0,         8'h2E};
    vecs[9] = '{1'b1, 3'd0, 32'hFFFF_FF00, 3'd0, 32'h0,         8'h00};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out_port), 32'(RST_V));
    check("reset_irq", 32'(irq), 32'h0);
    rd_check("reset_status", 3'd5, 32'h0);
    rd_check("reset_data", 3'd0, 32'(RST_V));
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycle();
    rd_check("reset_plen", 3'd1, 32'h1);

    // Register table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wd);
      else idle_cycle();
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
    end

    // Five-cycle pulse
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'd5);
    bus_write(3'd4, 32'h03);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("p5_out_c%0d", i), 32'(out_port), 32'h03);
      rd_check($sformatf("p5_busy_c%0d", i), 3'd5, 32'h1);
      idle_cycle();
    end
    check("p5_out_after", 32'(out_port), 32'h00);
    rd_check("p5_done", 3'd5, 32'h2);
    bus_write(3'd5, 32'h2);
    rd_check("p5_w1c", 3'd5, 32'h0);

    // PLEN=0 behaves as one cycle
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'h80);
    check("p0_out_c0", 32'(out_port), 32'h80);
    idle_cycle();
    check("p0_out_after", 32'(out_port), 32'h00);
    rd_check("p0_done", 3'd5, 32'h2);
    bus_write(3'd5, 32'h2);

    // Restart replaces mask and reloads the counter
    bus_write(3'd1, 32'd10);
    bus_write(3'd4, 32'h01);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rs_first_c%0d", i), 32'(out_port), 32'h01);
      if (i < 3) idle_cycle();
    end
    bus_write(3'd4, 32'h02);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rs_second_c%0d", i), 32'(out_port), 32'h02);
      if (i == 9) rd_check("rs_busy_last", 3'd5, 32'h1);
      idle_cycle();
    end
    check("rs_out_after", 32'(out_port), 32'h00);
    rd_check("rs_done", 3'd5, 32'h2);
    bus_write(3'd5, 32'h2);

    // Asynchronous reset mid-pulse
    bus_write(3'd0, 32'h30);
    bus_write(3'd1, 32'd5);
    bus_write(3'd4, 32'h04);
    check("ar_out_pulse", 32'(out_port), 32'h34);
    idle_cycle();
    idle_cycle();
    reset_n = 1'b0;
    #1;
    check("ar_out_reset", 32'(out_port), 32'(RST_V));
    rd_check("ar_status", 3'd5, 32'h0);
    rd_check("ar_plen", 3'd1, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) idle_cycle();
    rd_check("ar_no_done", 3'd5, 32'h0);
    check("ar_out_later", 32'(out_port), 32'(RST_V));

    // Expiry on the same edge as a done W1C
    bus_write(3'd1, 32'd3);
    bus_write(3'd4, 32'h01);
    idle_cycle();
    idle_cycle();
    bus_write(3'd5, 32'h2);
    rd_check("coinc_done", 3'd5, 32'h2);
    check("coinc_out", 32'(out_port), 32'(RST_V));
    bus_write(3'd5, 32'h2);
    rd_check("coinc_w1c", 3'd5, 32'h0);

    // Interrupt
    bus_write(3'd1, 32'd2);
    bus_write(3'd5, 32'h4);
`ifdef PIO_PULSE_IRQ_EN
    rd_check("irq_en_rd", 3'd5, 32'h4);
    bus_write(3'd4, 32'h01);
    check("irq_c0", 32'(irq), 32'h0);
    idle_cycle();
    check("irq_c1", 32'(irq), 32'h0);
    idle_cycle();
    check("irq_rise", 32'(irq), 32'h1);
    rd_check("irq_status", 3'd5, 32'h6);
    bus_write(3'd5, 32'h6);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_check("irq_status_clr", 3'd5, 32'h4);
`else
    rd_check("irq_en_rd", 3'd5, 32'h0);
    bus_write(3'd4, 32'h01);
    idle_cycle();
    idle_cycle();
    check("irq_off", 32'(irq), 32'h0);
    rd_check("irq_status", 3'd5, 32'h2);
    bus_write(3'd5, 32'h2);
    check("irq_off_clr", 32'(irq), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
